// File: rtl/gcm_deadlock_pkg.sv
// rtl/gcm_deadlock_pkg.sv - shared types and constants for the deadlock report scheduler
package gcm_deadlock_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_CNT_W       = 8;

    // Index width never collapses to zero, even for a single monitor.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gcm_deadlock_persist_cnt.sv
// rtl/gcm_deadlock_persist_cnt.sv - saturating persistence counter with per-episode reported bit
module gcm_deadlock_persist_cnt #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             mon_block,
    input  logic             set_reported,
    output logic [CNT_W-1:0] cnt,
    output logic             at_hold,
    output logic             confirmed
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD_CYCLES);

    logic reported;

    // A dropped flag ends the episode, so the next assertion is reported afresh.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            reported <= 1'b0;
        end else if (clear || !mon_block) begin
            cnt      <= '0;
            reported <= 1'b0;
        end else begin
            if (enable && (cnt != CNT_MAX))
                cnt <= cnt + 1'b1;
            if (set_reported)
                reported <= 1'b1;
        end
    end

    assign at_hold   = (cnt >= HOLD_V);
    assign confirmed = at_hold && !reported;

endmodule

// File: rtl/gcm_deadlock_report_sched.sv
// rtl/gcm_deadlock_report_sched.sv - debounced round-robin deadlock reporter; GCM_DEADLOCK_TIMESTAMP_EN adds report_time
module gcm_deadlock_report_sched
    import gcm_deadlock_pkg::*;
#(
    parameter int  NUM_MON     = 4,
    parameter int  HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int  CNT_W       = DEF_CNT_W,
    localparam int IDX_W       = idx_w(NUM_MON)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [CNT_W-1:0]   report_cycles,
    output logic               deadlock
`ifdef GCM_DEADLOCK_TIMESTAMP_EN
    ,
    output logic [31:0]        report_time
`endif
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt [NUM_MON];
    logic [NUM_MON-1:0] at_hold;
    logic [NUM_MON-1:0] confirmed;
    logic [NUM_MON-1:0] set_reported;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W:0]     sel_sum;
    logic               sel_found;
    logic               capture;

    for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
        gcm_deadlock_persist_cnt #(
            .CNT_W       (CNT_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_cnt (
            .clock        (clock),
            .reset        (reset),
            .enable       (enable),
            .clear        (clear),
            .mon_block    (mon_block[i]),
            .set_reported (set_reported[i]),
            .cnt          (cnt[i]),
            .at_hold      (at_hold[i]),
            .confirmed    (confirmed[i])
        );
    end

    // First confirmed monitor at or above rr_ptr, wrapping modulo NUM_MON.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_sum   = '0;
        for (int k = 0; k < NUM_MON; k++) begin
            sel_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sel_sum >= (IDX_W+1)'(NUM_MON))
                sel_sum = sel_sum - (IDX_W+1)'(NUM_MON);
            if (!sel_found && confirmed[sel_sum[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sel_sum[IDX_W-1:0];
            end
        end
    end

    assign rr_next = (sel_idx == IDX_W'(NUM_MON - 1)) ? '0 : sel_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_found && !clear) state_next = REPORT;
            REPORT:  if (report_ready)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // report_valid decodes the state register directly so reset drops it asynchronously.
    always_comb begin
        report_valid = (state == REPORT);
        capture      = (state == IDLE) && sel_found && !clear;
        set_reported = '0;
        if (capture)
            set_reported[sel_idx] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            report_idx    <= '0;
            report_cycles <= '0;
            rr_ptr        <= '0;
        end else if (capture) begin
            report_idx    <= sel_idx;
            report_cycles <= cnt[sel_idx];
            rr_ptr        <= rr_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            deadlock <= 1'b0;
        else if (clear)
            deadlock <= 1'b0;
        else if (|at_hold)
            deadlock <= 1'b1;
    end

`ifdef GCM_DEADLOCK_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            report_time <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (capture)
                report_time <= cycle_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gcm_deadlock_report_sched.sv
// tb/tb_gcm_deadlock_report_sched.sv - scoreboard bench for gcm_deadlock_report_sched
module tb_gcm_deadlock_report_sched;

    localparam int NUM_MON = 4;
    localparam int HOLD    = 4;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 2;
    localparam int CNT_MAX = 255;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               clear;
    logic [NUM_MON-1:0] mon_block;
    logic               report_valid;
    logic               report_ready;
    logic [IDX_W-1:0]   report_idx;
    logic [CNT_W-1:0]   report_cycles;
    logic               deadlock;

    gcm_deadlock_report_sched #(
        .NUM_MON     (NUM_MON),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .clear         (clear),
        .mon_block     (mon_block),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_idx    (report_idx),
        .report_cycles (report_cycles),
        .deadlock      (deadlock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int idx;
        int cyc;
    } rep_t;

    rep_t exp_q[$];

    int m_cnt [NUM_MON];
    bit m_rep [NUM_MON];
    int m_state;
    int m_rr;
    bit m_dl;
    bit m_cap;
    bit m_any;
    int m_sel;
    int m_j;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MON; i++) begin
                m_cnt[i] = 0;
                m_rep[i] = 0;
            end
            m_state = 0;
            m_rr    = 0;
            m_dl    = 0;
            exp_q.delete();
        end else begin
            m_cap = 0;
            m_sel = 0;
            m_any = 0;
            if (m_state == 0 && !clear) begin
                for (int k = 0; k < NUM_MON; k++) begin
                    m_j = (m_rr + k) % NUM_MON;
                    if (!m_cap && m_cnt[m_j] >= HOLD && !m_rep[m_j]) begin
                        m_cap = 1;
                        m_sel = m_j;
                    end
                end
            end
            for (int i = 0; i < NUM_MON; i++)
                if (m_cnt[i] >= HOLD) m_any = 1;
            if (m_cap) begin
                exp_q.push_back('{idx: m_sel, cyc: m_cnt[m_sel]});
                m_rr = (m_sel + 1) % NUM_MON;
            end
            if (clear)      m_dl = 0;
            else if (m_any) m_dl = 1;
            if (m_state == 0)      m_state = m_cap ? 1 : 0;
            else if (report_ready) m_state = 0;
            for (int i = 0; i < NUM_MON; i++) begin
                if (clear || !mon_block[i]) begin
                    m_cnt[i] = 0;
                    m_rep[i] = 0;
                end else begin
                    if (enable && m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    if (m_cap && m_sel == i) m_rep[i] = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("valid", report_valid, m_state);
            check("deadlock", deadlock, m_dl);
            if (report_valid) begin
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("sb_idx", report_idx, exp_q[0].idx);
                    check("sb_cycles", report_cycles, exp_q[0].cyc);
                    if (report_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        clear        = 1'b0;
        mon_block    = '0;
        report_ready = 1'b1;
        #2;
        check("rst_valid", report_valid, 0);
        check("rst_idx", report_idx, 0);
        check("rst_cycles", report_cycles, 0);
        check("rst_deadlock", deadlock, 0);
        step(1);
        reset = 1'b0;

        // single blocker latency
        mon_block = 4'b0100;
        step(4);
        check("lat_early", report_valid, 0);
        step(1);
        check("lat_valid", report_valid, 1);
        check("lat_idx", report_idx, 2);
        check("lat_cycles", report_cycles, HOLD);
        check("lat_deadlock", deadlock, 1);
        step(1);
        check("lat_one_cycle", report_valid, 0);
        mon_block = '0;
        step(2);

        // two blockers, round robin from pointer 0
        do_reset();
        mon_block = 4'b1010;
        step(5);
        check("rr_first_v", report_valid, 1);
        check("rr_first_idx", report_idx, 1);
        step(1);
        check("rr_gap", report_valid, 0);
        step(1);
        check("rr_second_v", report_valid, 1);
        check("rr_second_idx", report_idx, 3);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("rr_no_repeat", report_valid, 0);
        end
        mon_block = '0;
        step(2);

        // stall while the flag drops
        do_reset();
        report_ready = 1'b0;
        mon_block    = 4'b0001;
        step(5);
        mon_block = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("stall_valid", report_valid, 1);
            check("stall_idx", report_idx, 0);
        end
        report_ready = 1'b1;
        step(1);
        check("stall_done", report_valid, 0);
        mon_block = 4'b0001;
        step(4);
        check("reepisode_early", report_valid, 0);
        step(1);
        check("reepisode_valid", report_valid, 1);
        check("reepisode_cycles", report_cycles, HOLD);
        mon_block = '0;
        step(2);

        // short pulse never confirms
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        for (int r = 0; r < 2; r++) begin
            mon_block = 4'b0010;
            step(3);
            mon_block = '0;
            step(3);
            check("pulse_valid", report_valid, 0);
            check("pulse_deadlock", deadlock, 0);
        end

        // clear on the capture edge, then reset mid-report
        mon_block = 4'b0001;
        step(4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_valid", report_valid, 0);
        check("clr_deadlock", deadlock, 0);
        report_ready = 1'b0;
        step(5);
        check("pre_rst_valid", report_valid, 1);
        reset = 1'b1;
        #1;
        check("async_valid", report_valid, 0);
        check("async_idx", report_idx, 0);
        check("async_cycles", report_cycles, 0);
        check("async_deadlock", deadlock, 0);
        step(1);
        reset        = 1'b0;
        report_ready = 1'b1;
        mon_block    = '0;
        step(2);

        // enable gating
        enable    = 1'b0;
        mon_block = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("en_off_valid", report_valid, 0);
        end
        enable = 1'b1;
        step(4);
        check("en_early", report_valid, 0);
        step(1);
        check("en_valid", report_valid, 1);
        check("en_cycles", report_cycles, HOLD);
        mon_block = '0;
        step(2);

        // saturation while a report is stalled
        do_reset();
        report_ready = 1'b0;
        mon_block    = 4'b0011;
        step(5);
        check("sat_first_idx", report_idx, 0);
        step(300);
        report_ready = 1'b1;
        step(2);
        check("sat_valid", report_valid, 1);
        check("sat_idx", report_idx, 1);
        check("sat_cycles", report_cycles, CNT_MAX);
        mon_block = '0;
        step(2);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NUM_MON; b++)
                if ($urandom_range(0, 7) == 0) mon_block[b] = ~mon_block[b];
            report_ready = ($urandom_range(0, 3) != 0);
            clear        = ($urandom_range(0, 63) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            step(1);
        end
        clear        = 1'b0;
        enable       = 1'b1;
        report_ready = 1'b1;
        mon_block    = '0;
        step(10);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcm_deadlock_report_sched.md
Name: gcm_deadlock_report_sched

Overview:
- Collects per-instance deadlock monitor flags from the GCM_AE_HW datapath, one bit per monitored HLS sub-instance.
- Debounces each flag with a persistence counter and round-robins among confirmed blockers.
- Emits one valid/ready report per blocking episode to the debug/CSR side.
- Sits between the per-instance deadlock monitors and the top-level status interface.

Parameters:
- NUM_MON, 4, number of monitor inputs (1..16).
- HOLD_CYCLES, 16, consecutive sampled-high cycles required to confirm a block (1..255).
- CNT_W, 8, persistence counter width; must satisfy HOLD_CYCLES <= 2^CNT_W-1.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  counters advance only when high.
- clear  in  1  synchronous; clears sticky flag, reported mask and counters.
- mon_block  in  NUM_MON  raw block flags from the monitors.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts the report.
- report_idx  out  IDX_W  index of the reported monitor; IDX_W = max(1, clog2(NUM_MON)).
- report_cycles  out  CNT_W  counter value captured at selection.
- deadlock  out  1  sticky: some monitor has been confirmed since the last clear.

Behaviour:
- Reset (async assert): report_valid=0, report_idx=0, report_cycles=0, deadlock=0, all counters=0, reported mask=0, rr pointer=0, FSM=IDLE.
- Counter i:
  - mon_block[i]=0: counter goes to 0 next edge, and reported[i] clears.
  - mon_block[i]=1 && enable: counter increments, saturating at 2^CNT_W-1.
  - mon_block[i]=1 && !enable: counter holds.
- confirmed[i] = (cnt[i] >= HOLD_CYCLES) && !reported[i]. This is combinational from registers.
- FSM IDLE:
  - If any confirmed and !clear, pick the first confirmed index searching upward from the rr pointer, with wrap.
  - Register report_idx and report_cycles=cnt[idx], set reported[idx], set rr pointer = idx+1 (wrap to 0 at NUM_MON).
  - Go to REPORT with report_valid=1.
- FSM REPORT:
  - Payload is stable while valid && !ready.
  - On valid && ready: report_valid=0, return to IDLE. A new selection happens no earlier than the following edge, so there is at least one idle cycle between reports.
- Latency: mon_block[i] sampled high on edges 1..HOLD_CYCLES gives report_valid=1 after edge HOLD_CYCLES+1 (FSM idle, enable=1).
- deadlock: set on any edge where any cnt[i] >= HOLD_CYCLES. clear wins over set in the same cycle.
- clear:
  - Zeroes counters, reported mask and deadlock.
  - Blocks capture that cycle.
  - A report already in REPORT still completes its handshake with its payload unchanged.
- If mon_block[idx] drops during REPORT, the report still completes. reported[idx] clears, and a new episode is reported again after HOLD_CYCLES.
- Counter saturation never wraps. report_cycles saturates accordingly.
- NUM_MON=1: report_idx is a constant 0, and round-robin degenerates to a single input.
- Reset asserted mid-handshake drops report_valid immediately (async), without waiting for a clock edge.

Optional Feature:
- Macro: GCM_DEADLOCK_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps at 2^32).
  - Adds output report_time [31:0], captured together with report_idx and held stable during REPORT.
- Undefined: no counter and no report_time port. Behaviour is otherwise identical.

Decomposition:
- Package gcm_deadlock_pkg holds:
  - FSM state enum {IDLE, REPORT}.
  - IDX_W computation function.
  - Default constants for HOLD_CYCLES and CNT_W.
- Sub-module gcm_deadlock_persist_cnt: one saturating persistence counter with its reported bit, generated NUM_MON times.
- The top level contains the round-robin select, the FSM and the sticky flag.

Test Plan:
- HOLD_CYCLES=4, mon_block[2] high from edge 1, report_ready=1 -> report_valid high after edge 5 for one cycle, report_idx=2, report_cycles=4, deadlock=1.
- mon_block[1] and [3] both held high, rr pointer=0, report_ready=1 -> reports idx 1 then idx 3, each exactly once, with an idle cycle between them; no repeats while the flags stay high.
- report_ready=0 for 10 cycles while mon_block[0] drops -> payload stable (idx 0), valid held; after ready, no new report until mon_block[0] is high again for 4 sampled edges.
- mon_block[1] pulses high for 3 edges then low (HOLD=4) -> no report, deadlock stays 0, counter returns to 0.
- clear asserted on the same edge a capture would occur -> no report, deadlock=0; also assert reset during REPORT -> report_valid drops immediately and all outputs return to 0.
- enable=0 with mon_block[0]=1 for 20 cycles -> no report; enable=1 -> report arrives after 4 more sampled edges plus 1.
